// File: rtl/conv_ctrl_pkg.sv
// Shared constants and types for the 2x2 convolution window sequencer.
// Datapath widths are fixed by the downstream Convolution instance.
package conv_ctrl_pkg;

    localparam int unsigned DW       = 4;
    localparam int unsigned OW       = 10;
    localparam int unsigned NUM_TAPS = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_W = 2'd1,
        S_LOAD_I = 2'd2,
        S_CONV   = 2'd3
    } state_e;

    // Window tap order shared by IFM_x and INW_x: top-left, top-right, bottom-left, bottom-right.
    typedef enum logic [1:0] {
        WIN_TL = 2'd0,
        WIN_TR = 2'd1,
        WIN_BL = 2'd2,
        WIN_BR = 2'd3
    } win_pos_e;

    typedef logic [NUM_TAPS-1:0][DW-1:0] taps_t;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Input byte stream and result stream of the convolution window sequencer.
// master = stream source / result consumer, slave = the sequencer.
interface conv_window_ctrl_if;
    import conv_ctrl_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/conv_window_mux.sv
// Combinational 2x2 window selector: picks the TL, TR, BL, BR pixels anchored at (row, col)
// out of the raster-ordered frame buffer.
module conv_window_mux
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W = 4,
    localparam int unsigned NPIX = IMG_W * IMG_W,
    localparam int unsigned PW   = $clog2(NPIX),
    localparam int unsigned CW   = $clog2(IMG_W)
) (
    input  logic [NPIX-1:0][DW-1:0] pix,
    input  logic [CW-1:0]           row,
    input  logic [CW-1:0]           col,
    output taps_t                   ifm
);

    logic [PW-1:0] base;

    // row/col never exceed IMG_W-2, so base+IMG_W+1 always stays inside the buffer.
    always_comb begin
        base        = PW'(int'(row) * int'(IMG_W) + int'(col));
        ifm         = '0;
        ifm[WIN_TL] = pix[base];
        ifm[WIN_TR] = pix[base + PW'(1)];
        ifm[WIN_BL] = pix[base + PW'(IMG_W)];
        ifm[WIN_BR] = pix[base + PW'(IMG_W + 1)];
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the 2x2 Convolution datapath: loads a kernel and an IMG_W x IMG_W frame,
// then slides the window in raster order and streams the captured results out.
module conv_window_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_ctrl_if.slave bus,
    output logic [DW-1:0]     IFM_0,
    output logic [DW-1:0]     IFM_1,
    output logic [DW-1:0]     IFM_2,
    output logic [DW-1:0]     IFM_3,
    output logic [DW-1:0]     INW_0,
    output logic [DW-1:0]     INW_1,
    output logic [DW-1:0]     INW_2,
    output logic [DW-1:0]     INW_3,
    input  logic [OW-1:0]     Output
);

    localparam int unsigned NPIX = IMG_W * IMG_W;
    localparam int unsigned PW   = $clog2(NPIX);
    localparam int unsigned CW   = $clog2(IMG_W);

    localparam logic [PW-1:0] LAST_W   = PW'(NUM_TAPS - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_POS = CW'(IMG_W - 2);

    state_e                  state_q;
    logic [PW-1:0]           cnt_q;
    logic [CW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    taps_t                   w_q;
    logic [NPIX-1:0][DW-1:0] pix_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [OW-1:0]           out_data_q;

    taps_t ifm_win;
    taps_t ifm_hold_q;
    taps_t inw_hold_q;
    taps_t ifm_sel;
    taps_t inw_sel;
    logic  slot_free;
    logic  last_win;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign last_win  = (row_q == LAST_POS) && (col_q == LAST_POS);

    conv_window_mux #(
        .IMG_W (IMG_W)
    ) u_window_mux (
        .pix (pix_q),
        .row (row_q),
        .col (col_q),
        .ifm (ifm_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            w_q         <= '0;
            pix_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // A handoff frees the slot; a capture in S_CONV below refills it in the same cycle.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    state_q    <= S_LOAD_W;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                end

                S_LOAD_W: begin
                    if (bus.in_valid) begin
                        w_q[cnt_q[1:0]] <= bus.in_data;
                        if (cnt_q == LAST_W) begin
                            cnt_q   <= '0;
                            state_q <= S_LOAD_I;
                        end else begin
                            cnt_q <= cnt_q + PW'(1);
                        end
                    end
                end

                S_LOAD_I: begin
                    if (bus.in_valid) begin
                        pix_q[cnt_q] <= bus.in_data;
                        if (cnt_q == LAST_PIX) begin
                            cnt_q      <= '0;
                            row_q      <= '0;
                            col_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_CONV;
                        end else begin
                            cnt_q <= cnt_q + PW'(1);
                        end
                    end
                end

                S_CONV: begin
                    if (slot_free) begin
                        out_data_q  <= Output;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_win;
                        if (last_win) begin
                            // Next frame starts loading while this last result drains.
                            in_ready_q <= 1'b1;
                            state_q    <= S_LOAD_W;
                        end else if (col_q == LAST_POS) begin
                            col_q <= '0;
                            row_q <= row_q + CW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath inputs hold their last S_CONV values while buffers are being reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_hold_q <= '0;
            inw_hold_q <= '0;
        end else if (state_q == S_CONV) begin
            ifm_hold_q <= ifm_win;
            inw_hold_q <= w_q;
        end
    end

    always_comb begin
        ifm_sel = ifm_hold_q;
        inw_sel = inw_hold_q;
        if (state_q == S_CONV) begin
            ifm_sel = ifm_win;
            inw_sel = w_q;
        end
    end

    assign IFM_0 = ifm_sel[WIN_TL];
    assign IFM_1 = ifm_sel[WIN_TR];
    assign IFM_2 = ifm_sel[WIN_BL];
    assign IFM_3 = ifm_sel[WIN_BR];
    assign INW_0 = inw_sel[WIN_TL];
    assign INW_1 = inw_sel[WIN_TR];
    assign INW_2 = inw_sel[WIN_BL];
    assign INW_3 = inw_sel[WIN_BR];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl with a behavioural stand-in for the Convolution datapath.
module tb_conv_window_ctrl;
    import conv_ctrl_pkg::*;

    localparam int unsigned IMG_W = 4;
    localparam int unsigned NPIX  = IMG_W * IMG_W;
    localparam int unsigned NRES  = (IMG_W - 1) * (IMG_W - 1);

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    conv_window_ctrl_if bus ();

    logic [DW-1:0] ifm0, ifm1, ifm2, ifm3;
    logic [DW-1:0] inw0, inw1, inw2, inw3;
    logic [OW-1:0] dp_out;
    int            dp_sum;

    int   checks    = 0;
    int   failures  = 0;
    int   n_results = 0;
    exp_t exp_q[$];
    int   rdy_mode  = 0;
    bit   gaps      = 0;
    int   cur_w[NUM_TAPS];
    int   cur_p[NPIX];

    always #5 clk = ~clk;

    conv_window_ctrl #(
        .IMG_W (IMG_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .IFM_0  (ifm0),
        .IFM_1  (ifm1),
        .IFM_2  (ifm2),
        .IFM_3  (ifm3),
        .INW_0  (inw0),
        .INW_1  (inw1),
        .INW_2  (inw2),
        .INW_3  (inw3),
        .Output (dp_out)
    );

    // Convolution datapath: sum of the four pixel x weight products.
    always_comb begin
        dp_sum = int'(ifm0) * int'(inw0) + int'(ifm1) * int'(inw1)
               + int'(ifm2) * int'(inw2) + int'(ifm3) * int'(inw3);
        dp_out = OW'(dp_sum);
    end

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endfunction

    task automatic push_list(input int lst[NRES]);
        for (int i = 0; i < int'(NRES); i++) begin
            exp_q.push_back('{data: lst[i], last: (i == int'(NRES) - 1)});
        end
    endtask

    // Reference: every 2x2 window in raster order, weights applied TL,TR,BL,BR.
    task automatic push_model();
        int v;
        for (int r = 0; r < int'(IMG_W) - 1; r++) begin
            for (int c = 0; c < int'(IMG_W) - 1; c++) begin
                v = cur_w[0] * cur_p[r * IMG_W + c]
                  + cur_w[1] * cur_p[r * IMG_W + c + 1]
                  + cur_w[2] * cur_p[(r + 1) * IMG_W + c]
                  + cur_w[3] * cur_p[(r + 1) * IMG_W + c + 1];
                exp_q.push_back('{data: v,
                                  last: (r == int'(IMG_W) - 2) && (c == int'(IMG_W) - 2)});
            end
        end
    endtask

    task automatic send_beat(input int d);
        int guard;
        bit take;
        guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        forever begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(d);
            take         = bus.in_ready;
            @(posedge clk);
            if (take) break;
            guard++;
            if (guard > 300) begin
                timeout_fail("in_ready_wait");
                break;
            end
        end
    endtask

    task automatic load_frame();
        for (int k = 0; k < int'(NUM_TAPS); k++) send_beat(cur_w[k]);
        for (int i = 0; i < int'(NPIX); i++) send_beat(cur_p[i]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("in_ready_during_conv", int'(bus.in_ready), 0);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                timeout_fail("result_drain");
                exp_q.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_frame(input int w0, input int w1, input int w2, input int w3,
                             input int mode);
        cur_w[0] = w0;
        cur_w[1] = w1;
        cur_w[2] = w2;
        cur_w[3] = w3;
        for (int i = 0; i < int'(NPIX); i++) begin
            case (mode)
                0:       cur_p[i] = i;
                1:       cur_p[i] = 15;
                default: cur_p[i] = int'($urandom_range(0, 15));
            endcase
        end
    endtask

    initial begin : ready_drv
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((ph % 3) == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit            stall_prev;
        logic [OW-1:0] d_prev;
        logic          l_prev;
        exp_t          e;
        stall_prev = 1'b0;
        d_prev     = '0;
        l_prev     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_data_stable", int'(bus.out_data), int'(d_prev));
                    chk("stall_last_stable", int'(bus.out_last), int'(l_prev));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got %0d, expected no result",
                                 bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(bus.out_data), e.data);
                        chk("out_last", int'(bus.out_last), int'(e.last));
                    end
                    n_results++;
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                d_prev     = bus.out_data;
                l_prev     = bus.out_last;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int list_ones[NRES];
        int list_tl[NRES];
        int list_max[NRES];
        int base;
        int guard;

        list_ones = '{10, 14, 18, 26, 30, 34, 42, 46, 50};
        list_tl   = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        list_max  = '{900, 900, 900, 900, 900, 900, 900, 900, 900};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_ifm_inw", int'(ifm0) + int'(ifm1) + int'(ifm2) + int'(ifm3)
                         + int'(inw0) + int'(inw1) + int'(inw2) + int'(inw3), 0);

        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        chk("load_w_in_ready", int'(bus.in_ready), 1);

        // Directed frames with literal expected results.
        set_frame(1, 1, 1, 1, 0);
        push_list(list_ones);
        load_frame();
        wait_drain();

        set_frame(1, 0, 0, 0, 0);
        push_list(list_tl);
        load_frame();
        wait_drain();

        set_frame(15, 15, 15, 15, 1);
        push_list(list_max);
        load_frame();
        wait_drain();

        rdy_mode = 1;
        set_frame(1, 1, 1, 1, 0);
        push_list(list_ones);
        load_frame();
        wait_drain();

        // Random frames, input gaps and random backpressure, loaded back-to-back.
        gaps     = 1'b1;
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            set_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2);
            push_model();
            load_frame();
        end
        wait_drain();

        // Reset after the third result discards the frame; a reload produces the full list.
        gaps     = 1'b0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        base = n_results;
        set_frame(1, 1, 1, 1, 0);
        push_list(list_ones);
        load_frame();
        guard = 0;
        while (n_results < base + 3) begin
            @(negedge clk);
            #2;
            guard++;
            if (guard > 100) begin
                timeout_fail("third_result_wait");
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", int'(bus.out_valid), 0);
        chk("midreset_in_ready", int'(bus.in_ready), 0);
        exp_q.delete();
        @(negedge clk);
        chk("midreset_out_valid_next", int'(bus.out_valid), 0);
        rst_n = 1'b1;

        push_list(list_ones);
        load_frame();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
